// File: rtl/conv1d_mac_sequencer.sv
// Multi-cycle sequencer for the 8-tap 1D-conv MAC: one buffer read pair per cycle
// over the circular input window, int32 accumulate, result on a valid/ready handshake.
module conv1d_mac_sequencer #(
  parameter int unsigned KERNEL_LENGTH = 8,
  parameter int unsigned MAX_DEPTH     = 128,
  parameter int unsigned ADDR_W        = 10,
  parameter int unsigned BYTE_SIZE     = 8,
  parameter int unsigned INT32_SIZE    = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             abort,
  input  logic [7:0]                       cfg_depth,
  input  logic [INT32_SIZE-1:0]            cfg_input_offset,
  input  logic [$clog2(KERNEL_LENGTH)-1:0] start_x,
  input  logic                             start_valid,
  output logic                             start_ready,
  output logic                             rd_en,
  output logic [ADDR_W-1:0]                kw_addr,
  output logic [ADDR_W-1:0]                in_addr,
  input  logic [BYTE_SIZE-1:0]             kw_data,
  input  logic [BYTE_SIZE-1:0]             in_data,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [INT32_SIZE-1:0]            res_data,
  output logic [$clog2(KERNEL_LENGTH)-1:0] next_x,
  output logic                             busy
);

  localparam int unsigned XW = $clog2(KERNEL_LENGTH);
  localparam int unsigned DW = 8;
  localparam logic [DW-1:0] MAX_D   = DW'(MAX_DEPTH);
  localparam logic [XW-1:0] LAST_FX = XW'(KERNEL_LENGTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [DW-1:0]         depth_q, depth_d;
  logic [INT32_SIZE-1:0] offset_q, offset_d;
  logic [XW-1:0]         sx_q, sx_d;
  logic [XW-1:0]         fx_q, fx_d;
  logic [DW-1:0]         ch_q, ch_d;
  logic [INT32_SIZE-1:0] acc_q, acc_d;
  logic [XW-1:0]         next_x_q, next_x_d;
  logic                  rdv_q, rdv_d;

  logic [DW-1:0]         depth_clamped;
  logic                  last_ch;
  logic                  last_issue;
  logic [XW-1:0]         win_col;
  logic [INT32_SIZE-1:0] kw_ext;
  logic [INT32_SIZE-1:0] in_ext;
  logic [INT32_SIZE-1:0] term;

  assign depth_clamped = (cfg_depth > MAX_D) ? MAX_D : cfg_depth;
  assign last_ch       = (ch_q == (depth_q - DW'(1)));
  assign last_issue    = last_ch && (fx_q == LAST_FX);
  // Window column wraps naturally in XW bits because KERNEL_LENGTH is a power of two.
  assign win_col       = fx_q + sx_q;

  assign kw_ext = {{(INT32_SIZE-BYTE_SIZE){kw_data[BYTE_SIZE-1]}}, kw_data};
  assign in_ext = {{(INT32_SIZE-BYTE_SIZE){in_data[BYTE_SIZE-1]}}, in_data};
  assign term   = kw_ext * (in_ext + offset_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (start_valid) state_d = (depth_clamped == '0) ? S_DONE : S_ISSUE;
        S_ISSUE: if (last_issue)  state_d = S_DRAIN;
        S_DRAIN: state_d = S_DONE;
        S_DONE:  if (res_ready)   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // rdv_q marks cycles where the buffers return a pair requested on the previous cycle.
  always_comb begin
    depth_d  = depth_q;
    offset_d = offset_q;
    sx_d     = sx_q;
    fx_d     = fx_q;
    ch_d     = ch_q;
    next_x_d = next_x_q;
    rdv_d    = (state_q == S_ISSUE) && !abort;
    acc_d    = rdv_q ? (acc_q + term) : acc_q;
    if (abort) begin
      acc_d = '0;
      fx_d  = '0;
      ch_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_valid) begin
            depth_d  = depth_clamped;
            offset_d = cfg_input_offset;
            sx_d     = start_x;
            acc_d    = '0;
            fx_d     = '0;
            ch_d     = '0;
          end
        end
        S_ISSUE: begin
          if (last_ch) begin
            ch_d = '0;
            fx_d = fx_q + XW'(1);
          end else begin
            ch_d = ch_q + DW'(1);
          end
        end
        S_DONE: begin
          if (res_ready) next_x_d = sx_q + XW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      depth_q  <= '0;
      offset_q <= '0;
      sx_q     <= '0;
      fx_q     <= '0;
      ch_q     <= '0;
      acc_q    <= '0;
      next_x_q <= '0;
      rdv_q    <= 1'b0;
    end else begin
      depth_q  <= depth_d;
      offset_q <= offset_d;
      sx_q     <= sx_d;
      fx_q     <= fx_d;
      ch_q     <= ch_d;
      acc_q    <= acc_d;
      next_x_q <= next_x_d;
      rdv_q    <= rdv_d;
    end
  end

  always_comb begin
    start_ready = (state_q == S_IDLE);
    busy        = (state_q != S_IDLE);
    rd_en       = (state_q == S_ISSUE);
    res_valid   = (state_q == S_DONE);
    res_data    = acc_q;
    next_x      = next_x_q;
    kw_addr     = '0;
    in_addr     = '0;
    if (state_q == S_ISSUE) begin
      kw_addr = ADDR_W'(fx_q) * ADDR_W'(depth_q) + ADDR_W'(ch_q);
      in_addr = ADDR_W'(win_col) * ADDR_W'(depth_q) + ADDR_W'(ch_q);
    end
  end

endmodule

// File: doc/conv1d_mac_sequencer.md
Name: conv1d_mac_sequencer

Overview:
- Multi-cycle controller for the 8-tap 1D-conv MAC: replaces the single-cycle nested loop with one MAC per cycle.
- Sits between the CFU command decoder and the input/kernel byte buffers (synchronous-read memories, 1-cycle latency).
- Generates buffer read addresses over the 8-column circular input window, accumulates to int32, and returns the result on a valid/ready handshake.
- Also reports the next window head.

Parameters:
KERNEL_LENGTH, 8, taps per output (power of two; the window index wraps mod KERNEL_LENGTH)
MAX_DEPTH, 128, maximum input channels
ADDR_W, 10, buffer address width (log2(KERNEL_LENGTH*MAX_DEPTH))
BYTE_SIZE, 8, buffer element width
INT32_SIZE, 32, accumulator/result width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
abort  in  1  synchronous abort, returns to IDLE
cfg_depth  in  8  input channel count, sampled at start
cfg_input_offset  in  32  signed offset added to each input byte, sampled at start
start_x  in  3  window head column, sampled at start
start_valid  in  1  start request
start_ready  out  1  high only in IDLE
rd_en  out  1  buffer read strobe
kw_addr  out  ADDR_W  kernel buffer address
in_addr  out  ADDR_W  input buffer address
kw_data  in  8  signed kernel byte, valid the cycle after rd_en
in_data  in  8  signed input byte, valid the cycle after rd_en
res_valid  out  1  result valid
res_ready  in  1  result accept
res_data  out  32  signed accumulated result
next_x  out  3  (start_x+1) mod KERNEL_LENGTH of the last completed job
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset=0, async): state IDLE, acc=0; outputs reset to rd_en=0, res_valid=0, res_data=0, next_x=0, busy=0, kw_addr=0, in_addr=0. start_ready=1 after reset releases.
- States:
  - IDLE: start_ready=1. On start_valid&start_ready, latch depth, offset and start_x; clear acc, fx, ch.
    - Effective depth D = min(cfg_depth, MAX_DEPTH). cfg_depth 129..255 clamps to 128.
    - If D=0, go to DONE with res_data=0. Otherwise go to ISSUE.
  - ISSUE: rd_en=1 every cycle.
    - kw_addr = fx*D+ch.
    - in_addr = ((fx+start_x) mod 8)*D+ch.
    - ch counts 0..D-1, then wraps to 0 and fx increments; fx counts 0..7.
    - After the (fx=7, ch=D-1) issue cycle, go to DRAIN.
  - DRAIN: rd_en=0; accumulates the final returned pair. Next state DONE.
  - DONE: res_valid=1, res_data=acc, both held stable until res_ready. On handshake: go to IDLE and update next_x.
- Accumulate: in every cycle following an rd_en cycle, acc <= acc + kw_data*(sext(in_data)+offset).
  - Sum, product and accumulate are all computed mod 2^32 (int32 wrap); no saturation.
- Latency, N=8*D issue cycles:
  - The start handshake edge is cycle 0.
  - rd_en is high in cycles 1..N; DRAIN is cycle N+1; res_valid rises in cycle N+2.
  - D=0: res_valid in cycle 1.
- Handshake rules:
  - start_valid is ignored outside IDLE.
  - No bypass: after the result handshake, start_ready is high from the next cycle.
  - res_ready while res_valid=0 has no effect.
- abort=1: from any state, next cycle is IDLE with rd_en=0 and res_valid=0. acc is cleared and next_x is unchanged. abort has priority over start and over the result handshake in the same cycle.
- Reset mid-operation: all outputs take their reset values immediately. Any in-flight read data returning afterwards is ignored.

Test Plan:
1. D=1, offset=0, kernel all 1, input[0..7]=1..8, start_x=0 -> rd_en high cycles 1..8; kw_addr/in_addr 0..7; res_data=36 with res_valid in cycle 10; next_x=1 after handshake.
2. D=2, start_x=3, kernel all 2, input all -1, offset=128 -> in_addr sequence 6,7,8,...,15,0,1,...,5 (full sequence 6..15,0..5); res_data=4064 in cycle 18.
3. Wrap: D=1, offset=0x7FFFFFFF, input all 1, kernel all 1 -> each term is -2^31; res_data=0x00000000. Then D=200 (clamped to 128), kernel -128, input -128, offset 0 -> 1024 issue cycles; res_data=0x01000000.
4. Backpressure: hold res_ready=0 for 5 cycles after res_valid, with start_valid=1 throughout -> res_valid/res_data stable, start_ready=0, no new job; on res_ready=1 go to IDLE and accept a new start one cycle later.
5. abort=1 in cycle 4 of ISSUE (D=1) -> rd_en=0 and busy=0 next cycle, no res_valid. A following normal job returns the correct 36.
6. Async reset deasserted-to-asserted during DRAIN -> res_valid, rd_en and busy go to 0 without a clock edge. cfg_depth=0 start -> res_data=0 with res_valid in cycle 1.
